// File: rtl/l0_skew_feeder_pkg.sv
// Shared definitions for the west-edge skew feeder: tile instruction codes,
// default geometry, the skew-pipe stage record and lane slicing helpers.
package l0_skew_feeder_pkg;

  localparam int ROW_DEF   = 8;
  localparam int BW_DEF    = 4;
  localparam int DEPTH_DEF = 16;

  // Tile instruction encoding: bit 1 = execute, bit 0 = kernel loading.
  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  // One stage of the diagonal skew pipe.
  typedef struct packed {
    logic       pop;
    logic [1:0] inst;
  } skew_t;

  // Only load and execute may be tagged to a pop.
  function automatic logic inst_legal(input logic [1:0] inst);
    return (inst == INST_LOAD) || (inst == INST_EXEC);
  endfunction

endpackage

// Lane r of a packed row vector with w bits per lane.
`define L0_LANE(r, w) ((r) * (w)) +: (w)
// Lane r of the packed 2-bit-per-lane instruction vector.
`define L0_INST_LANE(r) ((r) * 2) +: 2

// File: rtl/l0_row_fifo.sv
// Single-row synchronous FIFO with a registered output word. dout holds its
// value between pops; push into a full FIFO or pop from an empty one is ignored.
module l0_row_fifo
  import l0_skew_feeder_pkg::*;
#(
  parameter int bw    = BW_DEF,
  parameter int depth = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [bw-1:0]            din,
  output logic [bw-1:0]            dout,
  output logic [$clog2(depth):0]   count
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(depth);

  logic [bw-1:0] mem_q [depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [bw-1:0] dout_q;
  logic          do_push, do_pop;

  assign do_push = push && (count_q != FULL_CNT);
  assign do_pop  = pop && (count_q != '0);

  // Storage array: written on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Pointers wrap naturally at depth (power of 2); count tracks occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        dout_q   <= mem_q[rd_ptr_q];
      end
      count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  assign dout  = dout_q;
  assign count = count_q;

endmodule

// File: rtl/l0_skew_feeder.sv
// West-edge input buffer of the systolic array. Every write pushes one lane
// into each row FIFO; every accepted read launches a pop that reaches row r
// r cycles after row 0, producing the diagonal skew the array expects.
module l0_skew_feeder
  import l0_skew_feeder_pkg::*;
#(
  parameter int row   = ROW_DEF,
  parameter int bw    = BW_DEF,
  parameter int depth = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic [row*bw-1:0]   in_data,
  input  logic                rd,
  input  logic [1:0]          rd_inst,
  output logic [row*bw-1:0]   out_data,
  output logic [2*row-1:0]    out_inst,
  output logic                o_full,
  output logic                o_ready,
  output logic                o_err
);

  localparam int CW = $clog2(depth) + 1;

  logic [CW-1:0] cnt [row];
  skew_t         tap [row];
  skew_t         skew_q [row-1];
  logic [1:0]    inst_q [row];
  logic          err_q;
  logic          wr_ok, rd_legal, rd_acc;

  // Lower rows always pop earlier, so the last row is the fullest and row 0
  // the emptiest; those two counts alone decide full and ready.
  assign o_full   = (cnt[row-1] == CW'(depth));
  assign o_ready  = (cnt[0] != '0);
  assign wr_ok    = wr && !o_full;
  assign rd_legal = inst_legal(rd_inst);
  assign rd_acc   = rd && o_ready && rd_legal;

  // Tap r selects which pop (if any) reaches row r this cycle; row 0 uses the
  // live accepted read so lane 0 updates on the same edge.
  always_comb begin
    tap[0] = '{pop: rd_acc, inst: (rd_acc ? rd_inst : INST_IDLE)};
    for (int r = 1; r < row; r++) tap[r] = skew_q[r-1];
  end

  // Skew shift register: one stage per row beyond row 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < row - 1; i++) skew_q[i] <= '0;
    end else begin
      skew_q[0] <= tap[0];
      for (int i = 1; i < row - 1; i++) skew_q[i] <= skew_q[i-1];
    end
  end

  // Per-lane instruction register: the popping stage's inst, idle otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < row; r++) inst_q[r] <= INST_IDLE;
    end else begin
      for (int r = 0; r < row; r++) inst_q[r] <= tap[r].pop ? tap[r].inst : INST_IDLE;
    end
  end

  // Sticky error: dropped write or read tagged with an illegal instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_q | (wr && o_full) | (rd && !rd_legal);
  end

  assign o_err = err_q;

  for (genvar r = 0; r < row; r++) begin : g_row
    l0_row_fifo #(
      .bw    (bw),
      .depth (depth)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_ok),
      .pop   (tap[r].pop),
      .din   (in_data[`L0_LANE(r, bw)]),
      .dout  (out_data[`L0_LANE(r, bw)]),
      .count (cnt[r])
    );
    assign out_inst[`L0_INST_LANE(r)] = inst_q[r];
  end

endmodule

// File: tb/tb_l0_skew_feeder.sv
// Directed bench for l0_skew_feeder: reset, skewed execute/load pops,
// full/drop/drain, ignored reads, and a streaming run interrupted by reset.
module tb_l0_skew_feeder;
  import l0_skew_feeder_pkg::*;

  localparam int ROW   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 16;

  // Clock / reset and DUT signals
  logic              clk = 1'b0;
  logic              reset;
  logic              wr;
  logic [ROW*BW-1:0] in_data;
  logic              rd;
  logic [1:0]        rd_inst;
  logic [ROW*BW-1:0] out_data;
  logic [2*ROW-1:0]  out_inst;
  logic              o_full;
  logic              o_ready;
  logic              o_err;

  always #5 clk = ~clk;

  l0_skew_feeder #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .in_data  (in_data),
    .rd       (rd),
    .rd_inst  (rd_inst),
    .out_data (out_data),
    .out_inst (out_inst),
    .o_full   (o_full),
    .o_ready  (o_ready),
    .o_err    (o_err)
  );

  // Scoreboard: accepted row vectors in write order, plus held lane values
  logic [ROW*BW-1:0] exp_q[$];
  logic [BW-1:0]     exp_data [ROW];
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ROW*BW-1:0] mkvec(input int a, input int m);
    logic [ROW*BW-1:0] v;
    for (int r = 0; r < ROW; r++) v[r*BW +: BW] = BW'(a + m * r);
    return v;
  endfunction

  function automatic logic [BW-1:0] lane_of(input logic [ROW*BW-1:0] v, input int r);
    return v[r*BW +: BW];
  endfunction

  task automatic do_reset();
    wr = 1'b0; rd = 1'b0; rd_inst = INST_IDLE;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    for (int r = 0; r < ROW; r++) exp_data[r] = '0;
    exp_q.delete();
    tick();
  endtask

  task automatic push_vec(input logic [ROW*BW-1:0] v);
    in_data = v; wr = 1'b1;
    exp_q.push_back(v);
    tick();
    wr = 1'b0;
  endtask

  // Issue nrd back-to-back reads tagged inst, then watch every lane until the
  // last row has drained; lane r pops entry j after edge T+r+j.
  task automatic run_window(input string tname, input int nrd, input logic [1:0] inst);
    for (int k = 0; k < nrd + ROW; k++) begin
      rd = (k < nrd); rd_inst = inst;
      tick();
      for (int r = 0; r < ROW; r++) begin
        int j;
        j = k - r;
        if (j >= 0 && j < nrd) begin
          exp_data[r] = lane_of(exp_q[j], r);
          check_eq($sformatf("%s k%0d lane%0d inst", tname, k, r), 32'(out_inst[2*r +: 2]), 32'(inst));
        end else begin
          check_eq($sformatf("%s k%0d lane%0d inst", tname, k, r), 32'(out_inst[2*r +: 2]), 32'(INST_IDLE));
        end
        check_eq($sformatf("%s k%0d lane%0d data", tname, k, r), 32'(out_data[r*BW +: BW]), 32'(exp_data[r]));
      end
    end
    rd = 1'b0; rd_inst = INST_IDLE;
    repeat (nrd) void'(exp_q.pop_front());
  endtask

  // wr and rd every cycle; row 0 starts popping one cycle after the first write.
  task automatic stream(input string tname, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      in_data = mkvec(5 * c + 1, 2); wr = 1'b1;
      rd = 1'b1; rd_inst = INST_EXEC;
      exp_q.push_back(in_data);
      tick();
      for (int r = 0; r < ROW; r++) begin
        int j;
        j = c - 1 - r;
        if (j >= 0) begin
          check_eq($sformatf("%s c%0d lane%0d data", tname, c, r), 32'(out_data[r*BW +: BW]), 32'(lane_of(exp_q[j], r)));
          check_eq($sformatf("%s c%0d lane%0d inst", tname, c, r), 32'(out_inst[2*r +: 2]), 32'(INST_EXEC));
        end else begin
          check_eq($sformatf("%s c%0d lane%0d data", tname, c, r), 32'(out_data[r*BW +: BW]), 32'd0);
          check_eq($sformatf("%s c%0d lane%0d inst", tname, c, r), 32'(out_inst[2*r +: 2]), 32'(INST_IDLE));
        end
      end
      check_eq($sformatf("%s c%0d err", tname, c), 32'(o_err), 32'd0);
    end
  endtask

  initial begin
    // Test 1: reset held with wr/rd active
    reset = 1'b0; wr = 1'b1; rd = 1'b1; rd_inst = INST_EXEC; in_data = mkvec(3, 1);
    tick(); tick();
    check_eq("rst out_data", 32'(out_data), 32'd0);
    check_eq("rst out_inst", 32'(out_inst), 32'd0);
    check_eq("rst full",     32'(o_full),   32'd0);
    check_eq("rst ready",    32'(o_ready),  32'd0);
    check_eq("rst err",      32'(o_err),    32'd0);
    wr = 1'b0; rd = 1'b0;
    reset = 1'b1;
    for (int r = 0; r < ROW; r++) exp_data[r] = '0;
    tick(); tick();
    check_eq("post-rst ready", 32'(o_ready), 32'd0);

    // Test 2: three vectors, lane r = r+1, r+2, r+3, drained with execute
    push_vec(mkvec(1, 1));
    check_eq("t2 ready after first write", 32'(o_ready), 32'd1);
    push_vec(mkvec(2, 1));
    push_vec(mkvec(3, 1));
    run_window("t2", 3, INST_EXEC);
    check_eq("t2 ready drained", 32'(o_ready), 32'd0);

    // Test 3: kernel load, lane r = 15-r; lane 7 sees load for one cycle, 7 after lane 0
    push_vec(mkvec(15, -1));
    run_window("t3", 1, INST_LOAD);
    check_eq("t3 err", 32'(o_err), 32'd0);

    // Test 4: fill to depth, drop one, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      push_vec(mkvec(3 * i, 1));
      check_eq($sformatf("t4 full w%0d", i), 32'(o_full), 32'(i == DEPTH - 1));
    end
    check_eq("t4 err before drop", 32'(o_err), 32'd0);
    in_data = mkvec(7, 5); wr = 1'b1;
    tick();
    wr = 1'b0;
    check_eq("t4 err after drop", 32'(o_err), 32'd1);
    check_eq("t4 full after drop", 32'(o_full), 32'd1);
    run_window("t4", DEPTH, INST_EXEC);
    check_eq("t4 ready drained", 32'(o_ready), 32'd0);
    check_eq("t4 full drained", 32'(o_full), 32'd0);

    // Test 5: read on empty ignored silently; illegal inst ignored with error
    do_reset();
    rd = 1'b1; rd_inst = INST_EXEC;
    tick();
    rd = 1'b0;
    check_eq("t5 empty rd err", 32'(o_err), 32'd0);
    for (int k = 0; k < ROW; k++) begin
      tick();
      check_eq($sformatf("t5 empty k%0d inst", k), 32'(out_inst), 32'd0);
    end
    check_eq("t5 empty rd err late", 32'(o_err), 32'd0);
    push_vec(mkvec(9, 1));
    rd = 1'b1; rd_inst = 2'b11;
    tick();
    rd = 1'b0; rd_inst = INST_IDLE;
    check_eq("t5 illegal err", 32'(o_err), 32'd1);
    check_eq("t5 illegal ready", 32'(o_ready), 32'd1);
    for (int k = 0; k < ROW; k++) begin
      tick();
      check_eq($sformatf("t5 illegal k%0d inst", k), 32'(out_inst), 32'd0);
      check_eq($sformatf("t5 illegal k%0d data", k), 32'(out_data), 32'd0);
    end

    // Test 6: steady stream, reset asserted asynchronously mid-stream
    do_reset();
    stream("t6a", 20);
    reset = 1'b0;
    #1;
    check_eq("t6 rst out_data", 32'(out_data), 32'd0);
    check_eq("t6 rst out_inst", 32'(out_inst), 32'd0);
    check_eq("t6 rst ready",    32'(o_ready),  32'd0);
    check_eq("t6 rst full",     32'(o_full),   32'd0);
    wr = 1'b0; rd = 1'b0;
    tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    check_eq("t6 count cleared", 32'(o_ready), 32'd0);
    check_eq("t6 inst idle", 32'(out_inst), 32'd0);
    stream("t6b", 20);
    wr = 1'b0; rd = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
